register_bank_write: RTL and testbench
======================================

// Module: register_bank_write
// PURPOSE
//  Write side of the 32-entry register file. Accepts write requests over a
//  valid/ready handshake, decodes the 5-bit address to a one-hot enable and
//  updates one of 32 DW-bit registers. Also provides a sequential bulk-clear
//  sweep. Reg_Q exposes all entries to the 32:1 read multiplexers.
// PARAMETERS
//  DW        32   data width of each register
// PORTS
//  clk         in   1       rising-edge clock; the block's only clock
//  rst_n       in   1       asynchronous, active-low reset
//  Wr_Valid    in   1       write request present
//  Wr_Ready    out  1       block can accept a write this cycle
//  Wr_Addr     in   5       target register index 0..31
//  Wr_Data     in   DW      write data
//  Clear_Req   in   1       request zeroing of all registers; sampled in IDLE only
//  Clear_Done  out  1       one-cycle pulse when the clear sweep completes
//  Reg_Q       out  32*DW   flattened registers; Reg_Q[i*DW +: DW] = reg i
// BEHAVIOUR
//  Reset (async, rst_n=0): all registers 0, state IDLE, pend_vld 0,
//    sweep counter 0, Clear_Done 0. Every output is valid during reset.
//  Wr_Ready = (state==IDLE) && !Clear_Req. This is combinational.
//  Accept: Wr_Valid && Wr_Ready at edge N loads pend_addr and pend_data,
//    and sets pend_vld=1.
//  Commit: at edge N+1, reg[pend_addr] <= pend_data. The new value is
//    visible on Reg_Q after edge N+1. pend_vld stays 1 only if another
//    write is accepted at N+1.
//  Throughput is 1 write/cycle. Back-to-back writes commit in acceptance
//    order. A same-address burst leaves the last data.
//  FSM IDLE -> CLEAR: at an edge where state==IDLE && Clear_Req. The sweep
//    counter is cleared to 0.
//  In CLEAR, each edge: reg[cnt] <= 0 and cnt++. After the edge that
//    writes reg 31: state -> IDLE and Clear_Done=1 for one cycle.
//    The sweep takes 32 cycles and Wr_Ready=0 throughout.
//  Simultaneous Clear_Req and Wr_Valid in IDLE: clear wins and the write
//    is not accepted (Wr_Ready=0). The requester must hold it.
//  A write pending when CLEAR starts commits on the first CLEAR edge. If it
//    targets the register being zeroed on that same edge, the zero wins.
//    Any register written before the sweep reaches it ends at 0.
//  Clear_Req asserted in CLEAR is ignored; there is no queued second sweep.
//  Reset mid-sweep aborts it: all registers 0, IDLE, no Clear_Done pulse.
// CONFIGURATION
//  REG_BANK_ZERO_REG_EN defined:
//    - reg 0 is hardwired to 0 and its Reg_Q slice is constant 0.
//    - Writes to address 0 complete the handshake but are discarded.
//  Undefined: reg 0 is an ordinary writable register.
// STRUCTURE
//  Package reg_bank_pkg:
//    - constants ADDR_W=5 and NUM_REGS=32
//    - FSM state encoding IDLE=1'b0, CLEAR=1'b1
//  Sub-module decoder5_to_32 (combinational, 5-bit index -> 32-bit one-hot
//    enable):
//    - the commit path drives it with pend_addr, qualified by pend_vld
//    - the clear path drives it with the sweep counter
// TESTING
//  1. Assert rst_n=0, then release -> all Reg_Q 0, Wr_Ready=1, Clear_Done=0.
//  2. Write addr 5, data 32'hDEADBEEF, accepted at edge N -> reg 5 holds
//     DEADBEEF after N+1; all other registers unchanged.
//  3. Writes on consecutive cycles: (1,32'h11), (2,32'h22), (3,32'h33), then
//     (3,32'h44) -> regs 1/2/3 end at 11/22/44; Wr_Ready held at 1.
//  4. Fill all 32 registers with nonzero values, then pulse Clear_Req ->
//     - Wr_Ready=0 for exactly 32 cycles
//     - Clear_Done pulses once
//     - all Reg_Q 0
//     Repeat with rst_n dropped at sweep cycle 10 -> all 0, no Clear_Done.
//  5. Clear_Req=1 and Wr_Valid=1 (addr 7, 32'hA5) in the same IDLE cycle
//     -> Wr_Ready=0 and reg 7 stays 0 after the sweep.
//  6. Write addr 0, data 32'h1234 -> reg 0 reads 0 with REG_BANK_ZERO_REG_EN
//     defined, and 32'h1234 without it.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared constants and FSM encoding for the register-bank write side.
package reg_bank_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef enum logic {
        StIdle  = 1'b0,
        StClear = 1'b1
    } state_e;

endpackage

// File: rtl/decoder5_to_32.sv
// Combinational 5-bit index to 32-bit one-hot enable, gated by en_i.
module decoder5_to_32
    import reg_bank_pkg::*;
(
    input  logic [ADDR_W-1:0]   idx_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/register_bank_write.sv
// Write side of the 32-entry register file: one-deep commit pipeline plus bulk-clear sweep.
// Optional build macro REG_BANK_ZERO_REG_EN hardwires register 0 to zero.
module register_bank_write
    import reg_bank_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   Wr_Valid,
    output logic                   Wr_Ready,
    input  logic [ADDR_W-1:0]      Wr_Addr,
    input  logic [DW-1:0]          Wr_Data,
    input  logic                   Clear_Req,
    output logic                   Clear_Done,
    output logic [NUM_REGS*DW-1:0] Reg_Q
);

    state_e              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                done_q;
    logic                pend_vld_q;
    logic [ADDR_W-1:0]   pend_addr_q;
    logic [DW-1:0]       pend_data_q;
    logic [DW-1:0]       regs_q [NUM_REGS];

    logic                accept;
    logic [NUM_REGS-1:0] wr_en_raw;
    logic [NUM_REGS-1:0] wr_en;
    logic [NUM_REGS-1:0] clr_en;

    assign Wr_Ready   = (state_q == StIdle) && !Clear_Req;
    assign accept     = Wr_Valid && Wr_Ready;
    assign Clear_Done = done_q;

    decoder5_to_32 u_dec_wr (
        .idx_i    (pend_addr_q),
        .en_i     (pend_vld_q),
        .onehot_o (wr_en_raw)
    );

    decoder5_to_32 u_dec_clr (
        .idx_i    (cnt_q),
        .en_i     (state_q == StClear),
        .onehot_o (clr_en)
    );

`ifdef REG_BANK_ZERO_REG_EN
    // Writes to reg 0 still complete the handshake but never land.
    assign wr_en = wr_en_raw & ~NUM_REGS'(1);
`else
    assign wr_en = wr_en_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            pend_vld_q <= accept;
            if (accept) begin
                pend_addr_q <= Wr_Addr;
                pend_data_q <= Wr_Data;
            end
        end
    end

    // Clear has priority so a commit colliding with the sweep slot ends at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (clr_en[i]) begin
                    regs_q[i] <= '0;
                end else if (wr_en[i]) begin
                    regs_q[i] <= pend_data_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (Clear_Req) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                    end
                end
                StClear: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign Reg_Q[g*DW +: DW] = regs_q[g];
    end

endmodule

// File: tb/tb_register_bank_write.sv
// Randomized and directed bench for register_bank_write against an array-based reference model.
module tb_register_bank_write;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int FW = NR * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          Wr_Valid;
    logic          Wr_Ready;
    logic [4:0]    Wr_Addr;
    logic [DW-1:0] Wr_Data;
    logic          Clear_Req;
    logic          Clear_Done;
    logic [FW-1:0] Reg_Q;

    always #5 clk = ~clk;

    register_bank_write #(.DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Wr_Valid   (Wr_Valid),
        .Wr_Ready   (Wr_Ready),
        .Wr_Addr    (Wr_Addr),
        .Wr_Data    (Wr_Data),
        .Clear_Req  (Clear_Req),
        .Clear_Done (Clear_Done),
        .Reg_Q      (Reg_Q)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: register contents, one outstanding write, sweep progress.
    logic [DW-1:0] mem [NR];
    bit            clearing;
    int            sweep_idx;
    bit            done_exp;
    bit            pend_v;
    int            pend_a;
    logic [DW-1:0] pend_d;

`ifdef REG_BANK_ZERO_REG_EN
    localparam bit ZeroReg = 1'b1;
`else
    localparam bit ZeroReg = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] model_flat();
        logic [FW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = mem[i];
        return f;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) mem[i] = '0;
        clearing  = 1'b0;
        sweep_idx = 0;
        done_exp  = 1'b0;
        pend_v    = 1'b0;
        pend_a    = 0;
        pend_d    = '0;
    endfunction

    function automatic void model_edge(input bit acc, input int a, input logic [DW-1:0] d,
                                       input bit c);
        if (pend_v && !(ZeroReg && pend_a == 0)) mem[pend_a] = pend_d;
        done_exp = 1'b0;
        if (clearing) begin
            mem[sweep_idx] = '0;
            sweep_idx++;
            if (sweep_idx == NR) begin
                clearing = 1'b0;
                done_exp = 1'b1;
            end
        end else if (c) begin
            clearing  = 1'b1;
            sweep_idx = 0;
        end
        pend_v = acc;
        pend_a = a;
        pend_d = d;
    endfunction

    // One clock: drive, check ready, advance model, check state after the edge.
    task automatic cycle(input bit v, input logic [4:0] a, input logic [DW-1:0] d, input bit c,
                         output bit rdy, output bit dn);
        bit exp_rdy;
        @(negedge clk);
        Wr_Valid  = v;
        Wr_Addr   = a;
        Wr_Data   = d;
        Clear_Req = c;
        #1;
        exp_rdy = !clearing && !c;
        rdy     = Wr_Ready;
        check_eq("ready", FW'(Wr_Ready), FW'(exp_rdy));
        @(posedge clk);
        model_edge(v && exp_rdy, int'(a), d, c);
        #1;
        dn = Clear_Done;
        check_eq("regq", Reg_Q, model_flat());
        check_eq("done", FW'(Clear_Done), FW'(done_exp));
    endtask

    task automatic idle(input int n);
        bit r, dn;
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, '0, 1'b0, r, dn);
    endtask

    task automatic fill_all();
        bit r, dn;
        for (int i = 0; i < NR; i++) begin
            cycle(1'b1, 5'(i), $urandom() | 32'h1, 1'b0, r, dn);
        end
        idle(1);
    endtask

    initial begin
        bit r, dn;
        int low_cnt, done_cnt;

        rst_n     = 1'b0;
        Wr_Valid  = 1'b0;
        Wr_Addr   = '0;
        Wr_Data   = '0;
        Clear_Req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_regq", Reg_Q, '0);
        check_eq("rst_ready", FW'(Wr_Ready), FW'(1));
        check_eq("rst_done", FW'(Clear_Done), FW'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single write.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, r, dn);
        idle(1);
        check_eq("reg5", FW'(Reg_Q[5*DW +: DW]), FW'(32'hDEADBEEF));

        // Back-to-back burst, same-address last wins.
        cycle(1'b1, 5'd1, 32'h11, 1'b0, r, dn);
        cycle(1'b1, 5'd2, 32'h22, 1'b0, r, dn);
        cycle(1'b1, 5'd3, 32'h33, 1'b0, r, dn);
        cycle(1'b1, 5'd3, 32'h44, 1'b0, r, dn);
        idle(1);
        check_eq("reg3", FW'(Reg_Q[3*DW +: DW]), FW'(32'h44));

        // Full sweep: ready low for 32 cycles after the request, one done pulse.
        fill_all();
        cycle(1'b0, 5'd0, '0, 1'b1, r, dn);
        low_cnt  = 0;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            cycle(1'b0, 5'd0, '0, 1'b0, r, dn);
            if (dn) done_cnt++;
            if (r) break;
            low_cnt++;
        end
        check_eq("sweep_len", FW'(low_cnt), FW'(32));
        check_eq("done_pulses", FW'(done_cnt), FW'(1));
        check_eq("swept_regq", Reg_Q, '0);

        // Reset at sweep cycle 10 aborts with no done pulse.
        fill_all();
        cycle(1'b0, 5'd0, '0, 1'b1, r, dn);
        idle(10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("abort_regq", Reg_Q, '0);
        check_eq("abort_ready", FW'(Wr_Ready), FW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            cycle(1'b0, 5'd0, '0, 1'b0, r, dn);
            if (dn) done_cnt++;
        end
        check_eq("abort_done", FW'(done_cnt), FW'(0));

        // Clear beats a simultaneous write.
        cycle(1'b1, 5'd7, 32'hA5, 1'b1, r, dn);
        check_eq("clr_vs_wr_ready", FW'(r), FW'(0));
        idle(34);
        check_eq("reg7", FW'(Reg_Q[7*DW +: DW]), FW'(0));

        // Address 0 behaviour depends on the build option.
        cycle(1'b1, 5'd0, 32'h1234, 1'b0, r, dn);
        idle(1);
        check_eq("reg0", FW'(Reg_Q[DW-1:0]), FW'(ZeroReg ? 32'h0 : 32'h1234));

        // Random traffic with occasional clears.
        for (int k = 0; k < 600; k++) begin
            cycle(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom(),
                  1'($urandom_range(0, 39) == 0), r, dn);
        end
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
